// File: rtl/decode_issue.sv
// decode_issue: decode/issue stage in front of the 16x16 register file.
//
// Takes fetched instructions over a valid/ready handshake, drives the rf read
// addresses combinationally, holds one issued instruction toward execute and
// keeps a scoreboard of registers with writes in flight. It stalls on RAW and
// WAW hazards. HLT drains outstanding writes and then raises hlt.
//
// Ports
//   clk, rst             rising-edge clock, async active-high reset
//   if_valid/if_instr    fetch request; if_ready accepts it
//   rf_rs, rf_rt         rf read addresses (rf_rt = rd field for SW/LHB/LLB)
//   ex_valid/ex_ready    issue register handshake toward execute
//   ex_op/ex_rd/ex_imm   issued opcode, destination, low byte
//   ex_we                issued instruction writes ex_rd
//   wb_valid/wb_rd       writeback retires a pending register
//   hlt                  halt complete, held until rst
//   issue_cnt/stall_cnt  saturating event counters
module decode_issue #(
  parameter int DW    = 16,
  parameter int NREG  = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [DW-1:0]    if_instr,
  output logic             if_ready,
  output logic [3:0]       rf_rs,
  output logic [3:0]       rf_rt,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [3:0]       ex_op,
  output logic [3:0]       ex_rd,
  output logic [7:0]       ex_imm,
  output logic             ex_we,
  input  logic             wb_valid,
  input  logic [3:0]       wb_rd,
  output logic             hlt,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t            r_state, w_state_nxt;
  logic [NREG-1:0]   r_pend, w_pend_nxt;
  logic              r_ex_valid;
  logic [3:0]        r_ex_op, r_ex_rd;
  logic [7:0]        r_ex_imm;
  logic              r_ex_we;
  logic              r_hlt;
  logic [CNT_W-1:0]  r_issue_cnt, r_stall_cnt;

  logic [3:0] w_op, w_rd, w_rs, w_rt;
  logic       w_use_rs, w_use_rt, w_use_rd, w_wr, w_is_hlt;
  logic       w_hazard, w_issue, w_issue_ex, w_drained;

  assign w_op = if_instr[15:12];
  assign w_rd = if_instr[11:8];
  assign w_rs = if_instr[7:4];
  assign w_rt = if_instr[3:0];

  // Opcode class decode: which fields are read and whether rd is written.
  always_comb begin
    w_use_rs = 1'b0;
    w_use_rt = 1'b0;
    w_use_rd = 1'b0;
    w_wr     = 1'b0;
    w_is_hlt = 1'b0;
    case (w_op)
      4'h0, 4'h1, 4'h2, 4'h3,
      4'h4, 4'h5, 4'h6, 4'h7: begin w_use_rs = 1'b1; w_use_rt = 1'b1; w_wr = 1'b1; end
      4'h8:                   begin w_use_rs = 1'b1; w_wr = 1'b1; end
      4'h9:                   begin w_use_rs = 1'b1; w_use_rd = 1'b1; end
      4'hA, 4'hB:             begin w_use_rd = 1'b1; w_wr = 1'b1; end
      4'hD:                   w_use_rs = 1'b1;
      4'hF:                   w_is_hlt = 1'b1;
      default: ;
    endcase
  end

  // Second read port carries the rd field for instructions that read rd.
  assign rf_rs = w_rs;
  assign rf_rt = w_use_rd ? w_rd : w_rt;

  // r_pend[0] is held at zero, so register 0 never raises a hazard. The
  // registered mask is used as-is: a same-cycle writeback does not bypass.
  assign w_hazard = (w_use_rs & r_pend[w_rs]) |
                    (w_use_rt & r_pend[w_rt]) |
                    ((w_use_rd | w_wr) & r_pend[w_rd]);

  assign if_ready   = (r_state == S_RUN) & ~w_hazard & (~r_ex_valid | ex_ready);
  assign w_issue    = if_valid & if_ready;
  assign w_issue_ex = w_issue & ~w_is_hlt;
  assign w_drained  = (r_pend == '0) & ~r_ex_valid;

  // Scoreboard update. A set and clear of the same register cannot coincide
  // because the WAW check blocks issue while rd is still pending.
  always_comb begin
    w_pend_nxt = r_pend;
    if (wb_valid)
      w_pend_nxt[wb_rd] = 1'b0;
    if (w_issue_ex && w_wr)
      w_pend_nxt[w_rd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:    if (w_issue && w_is_hlt) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (w_drained)           w_state_nxt = S_HALTED;
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_pend      <= '0;
      r_ex_valid  <= 1'b0;
      r_ex_op     <= '0;
      r_ex_rd     <= '0;
      r_ex_imm    <= '0;
      r_ex_we     <= 1'b0;
      r_hlt       <= 1'b0;
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_hlt   <= (w_state_nxt == S_HALTED);

      if (w_issue_ex) begin
        r_ex_valid <= 1'b1;
        r_ex_op    <= w_op;
        r_ex_rd    <= w_rd;
        r_ex_imm   <= if_instr[7:0];
        r_ex_we    <= w_wr;
      end else if (ex_ready) begin
        r_ex_valid <= 1'b0;
      end

      if (w_issue_ex && r_issue_cnt != '1)
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      if ((r_state == S_RUN) && if_valid && !if_ready && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign ex_valid  = r_ex_valid;
  assign ex_op     = r_ex_op;
  assign ex_rd     = r_ex_rd;
  assign ex_imm    = r_ex_imm;
  assign ex_we     = r_ex_we;
  assign hlt       = r_hlt;
  assign issue_cnt = r_issue_cnt;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed-vector bench for decode_issue. Inputs change 1ns
// after the rising edge; outputs are checked before the next edge.
module tb_decode_issue;

  logic        clk, rst;
  logic        if_valid, if_ready;
  logic [15:0] if_instr;
  logic [3:0]  rf_rs, rf_rt;
  logic        ex_valid, ex_ready;
  logic [3:0]  ex_op, ex_rd;
  logic [7:0]  ex_imm;
  logic        ex_we;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic        hlt;
  logic [15:0] issue_cnt, stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  decode_issue #(.DW(16), .NREG(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
    .rf_rs(rf_rs), .rf_rt(rf_rt),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op(ex_op), .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_we(ex_we),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .hlt(hlt), .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] ins);
    if_valid = v;
    if_instr = ins;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; if_valid = 1'b0; if_instr = 16'h0; wb_valid = 1'b0; wb_rd = 4'h0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    ex_ready = 1'b0;
    do_reset();
    // Reset state
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_op", ex_op, 0);
    chk("rst_ex_rd", ex_rd, 0);
    chk("rst_ex_we", ex_we, 0);
    chk("rst_hlt", hlt, 0);
    chk("rst_issue_cnt", issue_cnt, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    drive(1'b0, 16'h9321);
    chk("sw_rf_rs", rf_rs, 2);
    chk("sw_rf_rt_rd", rf_rt, 3);
    chk("rst_if_ready", if_ready, 1);

    // RAW stall: ADD r1,r2,r3 then SUB r4,r1,r5
    ex_ready = 1'b1;
    drive(1'b1, 16'h0123);
    chk("add_rf_rs", rf_rs, 2);
    chk("add_rf_rt", rf_rt, 3);
    tick();
    chk("add_ex_valid", ex_valid, 1);
    chk("add_ex_rd", ex_rd, 1);
    chk("add_ex_we", ex_we, 1);
    chk("add_ex_imm", ex_imm, 8'h23);
    chk("add_issue_cnt", issue_cnt, 1);
    drive(1'b1, 16'h1415);
    chk("raw_if_ready", if_ready, 0);
    tick();
    chk("raw_stall1", stall_cnt, 1);
    chk("raw_ex_drained", ex_valid, 0);
    tick();
    chk("raw_stall2", stall_cnt, 2);
    wb_valid = 1'b1; wb_rd = 4'd1; #1;
    chk("wb_no_bypass", if_ready, 0);
    tick();
    wb_valid = 1'b0; #1;
    chk("raw_stall3", stall_cnt, 3);
    chk("wb_if_ready", if_ready, 1);
    tick();
    chk("sub_ex_op", ex_op, 1);
    chk("sub_ex_rd", ex_rd, 4);
    chk("sub_issue_cnt", issue_cnt, 2);
    chk("sub_stall_hold", stall_cnt, 3);
    if_valid = 1'b0; wb_valid = 1'b1; wb_rd = 4'd4;
    tick();
    wb_valid = 1'b0;

    // LLB reads rd; r0 destination never becomes pending
    drive(1'b1, 16'h0200);
    tick();
    chk("r2_issue_cnt", issue_cnt, 3);
    drive(1'b1, 16'hB234);
    chk("llb_rf_rt_rd", rf_rt, 2);
    chk("llb_if_ready", if_ready, 0);
    tick();
    chk("llb_stall", stall_cnt, 4);
    if_valid = 1'b0; wb_valid = 1'b1; wb_rd = 4'd2;
    tick();
    wb_valid = 1'b0;
    drive(1'b1, 16'h0012);
    chk("r0dst_if_ready", if_ready, 1);
    tick();
    chk("r0dst_issue_cnt", issue_cnt, 4);
    chk("r0dst_ex_rd", ex_rd, 0);
    drive(1'b1, 16'h1000);
    chk("r0src_if_ready", if_ready, 1);
    tick();
    chk("r0src_issue_cnt", issue_cnt, 5);

    // Back-pressure from execute
    ex_ready = 1'b0;
    drive(1'b1, 16'h2567);
    chk("bp_if_ready", if_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_ex_valid", ex_valid, 1);
      chk("bp_ex_op", ex_op, 1);
      chk("bp_ex_imm", ex_imm, 8'h00);
    end
    chk("bp_stall", stall_cnt, 7);
    ex_ready = 1'b1; #1;
    chk("bp_resume_ready", if_ready, 1);
    tick();
    chk("bp_ex_op2", ex_op, 2);
    chk("bp_ex_rd2", ex_rd, 5);
    chk("bp_ex_imm2", ex_imm, 8'h67);
    chk("bp_issue_cnt6", issue_cnt, 6);
    drive(1'b1, 16'h3600);
    tick();
    chk("bp_ex_op3", ex_op, 3);
    chk("bp_issue_cnt7", issue_cnt, 7);

    // issue_cnt saturation with NOPs
    drive(1'b1, 16'hE000);
    for (int i = 0; i < 65527; i++) tick();
    chk("sat_fffe", issue_cnt, 16'hFFFE);
    tick();
    chk("sat_ffff", issue_cnt, 16'hFFFF);
    tick();
    chk("sat_hold", issue_cnt, 16'hFFFF);
    chk("sat_stall_hold", stall_cnt, 7);

    // LW r7 then HLT: drain then halt
    do_reset();
    chk("rst2_issue_cnt", issue_cnt, 0);
    drive(1'b1, 16'h8720);
    tick();
    chk("lw_ex_we", ex_we, 1);
    chk("lw_issue_cnt", issue_cnt, 1);
    drive(1'b1, 16'hF000);
    chk("hlt_if_ready", if_ready, 1);
    tick();
    drive(1'b1, 16'hE000);
    chk("drain_if_ready", if_ready, 0);
    chk("drain_ex_valid", ex_valid, 0);
    chk("drain_hlt0", hlt, 0);
    chk("drain_issue_cnt", issue_cnt, 1);
    tick();
    chk("drain_hlt_wait", hlt, 0);
    chk("drain_no_stall", stall_cnt, 0);
    wb_valid = 1'b1; wb_rd = 4'd7;
    tick();
    wb_valid = 1'b0; #1;
    chk("drain_hlt_late", hlt, 0);
    tick();
    chk("halted_hlt", hlt, 1);
    chk("halted_if_ready", if_ready, 0);
    chk("halted_issue_cnt", issue_cnt, 1);
    tick();
    chk("halted_hold", hlt, 1);

    // Reset pulse during DRAIN with r7 pending
    do_reset();
    drive(1'b1, 16'h8720);
    tick();
    drive(1'b1, 16'hF000);
    tick();
    drive(1'b0, 16'h0070);
    chk("pre_rst_drain", if_ready, 0);
    rst = 1'b1; #1;
    chk("mid_rst_ex_valid", ex_valid, 0);
    chk("mid_rst_ex_op", ex_op, 0);
    chk("mid_rst_ex_rd", ex_rd, 0);
    chk("mid_rst_issue_cnt", issue_cnt, 0);
    chk("mid_rst_hlt", hlt, 0);
    tick();
    rst = 1'b0;
    drive(1'b1, 16'h0070);
    chk("post_rst_if_ready", if_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
